// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// Latency: one cycle from an accepting edge to out_data/out_valid; one transfer per cycle sustained.
// Backpressure: in_ready comes from registered state (and flush/rst) only, so there is no
//   combinational path from out_ready; the skid entry absorbs the word in flight when a stall begins.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   flush           squash all held entries at the next edge (branch/jump redirect)
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload (out_data driven by main register)
//   occupancy       number of held entries, 0..2
module pipe_stage_reg #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] main_nxt;
   logic [WIDTH-1:0] skid_q;
   logic [WIDTH-1:0] skid_nxt;
   logic             in_fire;
   logic             out_fire;

   // Encoding doubles as the entry count.
   assign occupancy = state;
   assign out_valid = (state != EMPTY);
   assign in_ready  = (state != FULL) && !flush && !rst;
   assign out_data  = main_q;

   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      if (flush) begin
         // A concurrent out_fire still completes; data registers are left as they are.
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state_nxt = ONE;
                  main_nxt  = in_data;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_nxt = in_data;
               end else if (in_fire) begin
                  state_nxt = FULL;
                  skid_nxt  = in_data;
               end else if (out_fire) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only the drain side can move.
               if (out_fire) begin
                  state_nxt = ONE;
                  main_nxt  = skid_q;
               end
            end
            default: begin
               state_nxt = EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= EMPTY;
         main_q <= RESET_VALUE;
         skid_q <= RESET_VALUE;
      end else begin
         state  <= state_nxt;
         main_q <= main_nxt;
         skid_q <= skid_nxt;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed reset/stream/stall/flush vectors,
// then a randomized run against a queue scoreboard.
module tb_pipe_stage_reg;

   localparam int          W    = 32;
   localparam logic [31:0] RSTV = 32'hCAFE_0001;

   logic          clk;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [1:0]    occupancy;

   int total;
   int bad;

   pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RSTV)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 ns after it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] q[$];
   logic [31:0] nd;
   logic        iv, ordy, fl, ir0, ovm, irm;

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;

      // Reset with an offer pending: nothing may be captured.
      cyc(); cyc();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_occ",       {30'd0, occupancy}, 32'd0);
      chk("rst_out_data",  out_data, RSTV);
      chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      cyc();
      chk("post_rst_occ", {30'd0, occupancy}, 32'd0);

      // Streaming 1..8 with out_ready held high.
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = i;
         #1;
         chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
         if (i > 1) chk("stream_data_pre", out_data, i - 1);
         cyc();
         chk("stream_occ",  {30'd0, occupancy}, 32'd1);
         chk("stream_data", out_data, i);
         chk("stream_vld",  {31'd0, out_valid}, 32'd1);
      end
      in_valid = 1'b0;
      cyc();
      chk("stream_empty_vld", {31'd0, out_valid}, 32'd0);
      chk("stream_empty_occ", {30'd0, occupancy}, 32'd0);
      chk("empty_data_hold",  out_data, 32'h8);
      cyc();
      chk("empty_data_stable", out_data, 32'h8);

      // Stall and skid: 0xA, 0xB accepted, 0xC held off.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hA;
      cyc();
      chk("stall_occ1", {30'd0, occupancy}, 32'd1);
      chk("stall_ir1",  {31'd0, in_ready}, 32'd1);
      in_data = 32'hB;
      cyc();
      chk("stall_occ2", {30'd0, occupancy}, 32'd2);
      chk("stall_ir0",  {31'd0, in_ready}, 32'd0);
      in_data = 32'hC;
      cyc();
      chk("stall_hold_occ",  {30'd0, occupancy}, 32'd2);
      chk("stall_hold_data", out_data, 32'hA);
      out_ready = 1'b1;
      #1;
      chk("drain_a_vld", {31'd0, out_valid}, 32'd1);
      chk("drain_a",     out_data, 32'hA);
      chk("drain_ir_full", {31'd0, in_ready}, 32'd0);
      cyc();
      chk("drain_b",    out_data, 32'hB);
      chk("drain_occ1", {30'd0, occupancy}, 32'd1);
      chk("drain_ir_rise", {31'd0, in_ready}, 32'd1);
      cyc();
      chk("drain_c",    out_data, 32'hC);
      chk("drain_occc", {30'd0, occupancy}, 32'd1);
      in_valid = 1'b0;
      cyc();
      chk("drain_done", {30'd0, occupancy}, 32'd0);

      // Flush while FULL with a new offer present.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h11;
      cyc();
      in_data = 32'h22;
      cyc();
      chk("fl_full_occ", {30'd0, occupancy}, 32'd2);
      flush = 1'b1; in_data = 32'h33;
      #1;
      chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
      chk("fl_out_vld",  {31'd0, out_valid}, 32'd1);
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_vld_after", {31'd0, out_valid}, 32'd0);
      chk("fl_occ_after", {30'd0, occupancy}, 32'd0);
      chk("fl_data_kept", out_data, 32'h11);
      out_ready = 1'b1;
      cyc(); cyc();
      chk("fl_no_33", {31'd0, out_valid}, 32'd0);

      // Flush with a concurrent drain in ONE.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h44;
      cyc();
      in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
      #1;
      chk("fld_vld",  {31'd0, out_valid}, 32'd1);
      chk("fld_data", out_data, 32'h44);
      cyc();
      flush = 1'b0;
      chk("fld_occ", {30'd0, occupancy}, 32'd0);
      chk("fld_vld_after", {31'd0, out_valid}, 32'd0);

      // Reset mid-transfer discards held entries.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h55;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0; in_valid = 1'b0;
      chk("midrst_occ",  {30'd0, occupancy}, 32'd0);
      chk("midrst_data", out_data, RSTV);

      // Randomized run against a queue scoreboard.
      q.delete();
      for (int c = 0; c < 3000; c++) begin
         iv   = ($urandom_range(0, 99) < 60);
         ordy = ($urandom_range(0, 99) < 60);
         fl   = ($urandom_range(0, 99) < 5);
         nd   = $urandom;
         in_valid = iv; in_data = nd; flush = fl; out_ready = 1'b0;
         #1;
         ir0 = in_ready;
         out_ready = ordy;
         #1;
         irm = (q.size() < 2) && !fl;
         ovm = (q.size() != 0);
         chk("rnd_ir_indep", {31'd0, in_ready}, {31'd0, ir0});
         chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, irm});
         chk("rnd_out_vld",  {31'd0, out_valid}, {31'd0, ovm});
         chk("rnd_occ",      {30'd0, occupancy}, q.size());
         if (ovm && ordy) begin
            chk("rnd_data", out_data, q[0]);
            void'(q.pop_front());
         end
         if (fl) q.delete();
         else if (iv && irm) q.push_back(nd);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
